// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared types and constants for the data-memory SRAM controller.
//   state_t           : controller FSM states (IDLE, LOW, HIGH, DONE)
//   op_t              : captured operation (OP_RD, OP_WR)
//   HALF_W            : width of one SRAM access (halfword)
//   DEFAULT_BASE_ADDR : byte address that maps to SRAM location 0
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int          HALF_W            = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_ctrl_wait_cnt.sv
// sram_wait_cnt
// Loadable 4-bit down-counter that times one halfword phase.
// The counter is loaded with the number of extra wait cycles when a phase
// starts; the phase's last cycle is the one in which the count is zero.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load_i        : load value_i (takes priority over enable_i)
//   value_i[3:0]  : load value
//   enable_i      : count down by one (saturates at zero)
//   last_o        : current count is zero (last cycle of the phase)
//   next_last_o   : count after this edge will be zero (next cycle is last)
module sram_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] value_i,
    input  logic       enable_i,
    output logic       last_o,
    output logic       next_last_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (enable_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o      = (cnt_q == 4'd0);
    // Lets the FSM register the write strobe one cycle ahead of the phase end.
    assign next_last_o = (cnt_d == 4'd0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl
// Responder end of the pipeline's data-memory interface. Each 32-bit word
// request is performed as two 16-bit accesses (low halfword, then high
// halfword) on an external asynchronous SRAM. ready is low while an access
// is in flight so the pipeline freezes until it completes.
//
// Handshake: the requester raises rd_en or wr_en and holds it, with address
// and write_data, until it sees ready=1. ready falls combinationally in the
// cycle the request appears and rises for exactly one cycle (DONE) when the
// access completes; read_data is valid in that cycle after a read. A request
// still present in IDLE after DONE is a new request.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   rd_en, wr_en    : word read / write request (write wins if both)
//   address[31:0]   : byte address; address[1:0] ignored
//   write_data[31:0]: word to store
//   read_data[31:0] : loaded word, held until the next read completes
//   ready           : 1 = idle or access complete, 0 = stall
//   sram_addr       : SRAM halfword address
//   sram_dq_out     : data driven onto the SRAM DQ bus
//   sram_dq_in      : data returned by the SRAM
//   sram_dq_oe      : 1 = controller drives DQ
//   sram_we_n       : SRAM write strobe, active low
//   dbg_state[1:0]  : current FSM state, for observation only
//   err             : (only with SRAM_CTRL_ERR_EN) sticky request-error flag
//
// Optional feature macro: SRAM_CTRL_ERR_EN adds the err output, set when a
// request is accepted with both enables, a misaligned address, or an address
// below BASE_ADDR. It clears only on rst.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [HALF_W-1:0]   sram_dq_out,
    input  logic [HALF_W-1:0]   sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n,
    output logic [1:0]          dbg_state
`ifdef SRAM_CTRL_ERR_EN
    ,
    output logic                err
`endif
);

    localparam logic [3:0] WAIT_V = 4'(WAIT_CYCLES);
    // With no wait cycles a phase is a single cycle and we_n must still pulse.
    localparam bit SINGLE_CYCLE = (WAIT_CYCLES == 0);

    state_t                 state_q;
    op_t                    op_q;
    logic [SRAM_AW-2:0]     word_q;
    logic [HALF_W-1:0]      wdata_hi_q;
    logic [31:0]            read_data_q;
    logic [SRAM_AW-1:0]     sram_addr_q;
    logic [HALF_W-1:0]      dq_out_q;
    logic                   dq_oe_q;
    logic                   we_n_q;

    logic                   request;
    logic [31:0]            word_in;
    logic                   is_wr;
    logic                   cnt_load;
    logic                   cnt_en;
    logic                   cnt_last;
    logic                   cnt_next_last;
    logic                   we_low_next;
    logic                   unused_word_bits;

    assign request = rd_en | wr_en;
    assign is_wr   = (op_q == OP_WR);

    // Wrap-around subtraction; the shift drops address[1:0].
    assign word_in = (address - BASE_ADDR) >> 2;
    // Upper word bits are silently truncated by the SRAM address width.
    assign unused_word_bits = ^word_in[31:SRAM_AW-1];

    // Reload at the start of each phase: on acceptance and at the end of LOW.
    assign cnt_load = ((state_q == IDLE) && request) ||
                      ((state_q == LOW) && cnt_last);
    assign cnt_en   = (state_q == LOW) || (state_q == HIGH);

    // we_n is low in every cycle of a phase except its last (data hold),
    // unless the phase is only one cycle long.
    assign we_low_next = !cnt_next_last || SINGLE_CYCLE;

    sram_wait_cnt u_wait_cnt (
        .clk         (clk),
        .rst         (rst),
        .load_i      (cnt_load),
        .value_i     (WAIT_V),
        .enable_i    (cnt_en),
        .last_o      (cnt_last),
        .next_last_o (cnt_next_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request) begin
                        op_q        <= wr_en ? OP_WR : OP_RD;
                        word_q      <= word_in[SRAM_AW-2:0];
                        wdata_hi_q  <= write_data[31:16];
                        sram_addr_q <= {word_in[SRAM_AW-2:0], 1'b0};
                        if (wr_en) begin
                            dq_out_q <= write_data[15:0];
                        end
                        dq_oe_q     <= wr_en;
                        we_n_q      <= !(wr_en && we_low_next);
                        state_q     <= LOW;
                    end
                end
                LOW: begin
                    if (cnt_last) begin
                        if (!is_wr) begin
                            read_data_q[15:0] <= sram_dq_in;
                        end
                        sram_addr_q <= {word_q, 1'b1};
                        if (is_wr) begin
                            dq_out_q <= wdata_hi_q;
                        end
                        state_q <= HIGH;
                    end
                    we_n_q <= !(is_wr && we_low_next);
                end
                HIGH: begin
                    if (cnt_last) begin
                        if (!is_wr) begin
                            read_data_q[31:16] <= sram_dq_in;
                        end
                        dq_oe_q <= 1'b0;
                        we_n_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        we_n_q <= !(is_wr && we_low_next);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_CTRL_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && request &&
                     ((rd_en && wr_en) || (address[1:0] != 2'b00) ||
                      (address < BASE_ADDR))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    assign ready       = ((state_q == IDLE) && !request) || (state_q == DONE);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign dbg_state   = state_q;

endmodule
